// File: rtl/cronometro_pkg.sv
// Shared types and sizes for the stopwatch register-file write path.
package cronometro_pkg;

  localparam int RF_ADDR_W = 4;
  localparam int RF_DEPTH  = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } wr_state_e;

  // Who owns the frame currently on the write port.
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_A,
    OWN_B,
    OWN_CLR
  } wr_owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer only moves when the caller
// commits a grant through advance_i.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  logic favourB_q;

  // A lone requester always wins; a tie goes to whoever the pointer favours.
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = favourB_q ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      favourB_q <= 1'b0;
    end else if (advance_i && (gnt_o != 2'b00)) begin
      favourB_q <= gnt_o[0];
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Write-port scheduler for the 16-entry register file: frames every write as
// SETUP/STROBE/HOLD, arbitrates A/B round-robin and runs the clear sweep.
module regfile_write_scheduler
  import cronometro_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_a,
  input  logic [RF_ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0]    data_a,
  output logic                 gnt_a,
  input  logic                 req_b,
  input  logic [RF_ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0]    data_b,
  output logic                 gnt_b,
  input  logic                 clr_start,
  output logic                 clr_busy,
  output logic [RF_ADDR_W-1:0] address,
  output logic                 wclk,
  output logic [DATA_W-1:0]    wdata
);

  wr_state_e            state_q, state_d;
  wr_owner_e            owner_q, owner_d;
  logic [RF_ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic                 wclk_q, wclk_d;
  logic                 gntA_q, gntA_d;
  logic                 gntB_q, gntB_d;
  logic                 clrBusy_q, clrBusy_d;
  logic                 sweepRun_q, sweepRun_d;
  logic [RF_ADDR_W-1:0] sweepCnt_q, sweepCnt_d;
  logic [RF_ADDR_W:0]   sweepInc;
  logic                 clrAccept;
  logic                 advance;
  logic [1:0]           arbGnt;

  rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_i     ({req_b, req_a}),
    .advance_i (advance),
    .gnt_o     (arbGnt)
  );

  // The carry out of the sweep increment is the done flag: no entry past 15.
  assign sweepInc  = {1'b0, sweepCnt_q} + {{RF_ADDR_W{1'b0}}, 1'b1};
  assign clrAccept = clr_start && !clrBusy_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    address_d  = address_q;
    wdata_d    = wdata_q;
    wclk_d     = 1'b0;
    gntA_d     = 1'b0;
    gntB_d     = 1'b0;
    clrBusy_d  = clrBusy_q;
    sweepRun_d = sweepRun_q;
    sweepCnt_d = sweepCnt_q;
    advance    = 1'b0;

    if (clrAccept) begin
      clrBusy_d = 1'b1;
    end

    unique case (state_q)
      SETUP: begin
        state_d = STROBE;
        wclk_d  = 1'b1;
        gntA_d  = (owner_q == OWN_A);
        gntB_d  = (owner_q == OWN_B);
      end
      STROBE: begin
        state_d = HOLD;
      end
      default: begin
        // Arbitration point: sweep continuation, sweep start, then A/B.
        if (sweepRun_q && !sweepInc[RF_ADDR_W]) begin
          state_d    = SETUP;
          owner_d    = OWN_CLR;
          sweepCnt_d = sweepInc[RF_ADDR_W-1:0];
          address_d  = sweepInc[RF_ADDR_W-1:0];
          wdata_d    = '0;
        end else if (!sweepRun_q && (clrAccept || clrBusy_q)) begin
          state_d    = SETUP;
          owner_d    = OWN_CLR;
          sweepRun_d = 1'b1;
          sweepCnt_d = '0;
          address_d  = '0;
          wdata_d    = '0;
        end else begin
          if (sweepRun_q) begin
            sweepRun_d = 1'b0;
            clrBusy_d  = 1'b0;
          end
          if (arbGnt[0]) begin
            advance   = 1'b1;
            state_d   = SETUP;
            owner_d   = OWN_A;
            address_d = addr_a;
            wdata_d   = data_a;
          end else if (arbGnt[1]) begin
            advance   = 1'b1;
            state_d   = SETUP;
            owner_d   = OWN_B;
            address_d = addr_b;
            wdata_d   = data_b;
          end else begin
            state_d = IDLE;
            owner_d = OWN_NONE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_NONE;
      address_q  <= '0;
      wdata_q    <= '0;
      wclk_q     <= 1'b0;
      gntA_q     <= 1'b0;
      gntB_q     <= 1'b0;
      clrBusy_q  <= 1'b0;
      sweepRun_q <= 1'b0;
      sweepCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      address_q  <= address_d;
      wdata_q    <= wdata_d;
      wclk_q     <= wclk_d;
      gntA_q     <= gntA_d;
      gntB_q     <= gntB_d;
      clrBusy_q  <= clrBusy_d;
      sweepRun_q <= sweepRun_d;
      sweepCnt_q <= sweepCnt_d;
    end
  end

  assign address  = address_q;
  assign wdata    = wdata_q;
  assign wclk     = wclk_q;
  assign gnt_a    = gntA_q;
  assign gnt_b    = gntB_q;
  assign clr_busy = clrBusy_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Self-checking bench for regfile_write_scheduler: a frame-level model is
// compared every cycle, and directed scenarios pin literal expectations.
module tb_regfile_write_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_a = 1'b0;
  logic [3:0]  addr_a = '0;
  logic [15:0] data_a = '0;
  logic        gnt_a;
  logic        req_b = 1'b0;
  logic [3:0]  addr_b = '0;
  logic [15:0] data_b = '0;
  logic        gnt_b;
  logic        clr_start = 1'b0;
  logic        clr_busy;
  logic [3:0]  address;
  logic        wclk;
  logic [15:0] wdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          who;
    logic [3:0]  addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;
  wr_t wlog[$];

  regfile_write_scheduler #(.DATA_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_a     (req_a),
    .addr_a    (addr_a),
    .data_a    (data_a),
    .gnt_a     (gnt_a),
    .req_b     (req_b),
    .addr_b    (addr_b),
    .data_b    (data_b),
    .gnt_b     (gnt_b),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .address   (address),
    .wclk      (wclk),
    .wdata     (wdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Frame-level model: a write is a 3-cycle frame, phase 1 is the strobe.
  bit          mInFrame = 0;
  int          mPhase = 0;
  logic [3:0]  mAddr = '0;
  logic [15:0] mData = '0;
  int          mWho = 0;
  int          mSweepNext = -1;
  bit          mFavourB = 0;

  function automatic bit modelBusy();
    return (mSweepNext >= 0) || (mInFrame && mWho == 2);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mInFrame   = 0;
      mPhase     = 0;
      mAddr      = '0;
      mData      = '0;
      mWho       = 0;
      mSweepNext = -1;
      mFavourB   = 0;
    end else begin
      bit accept;
      bit pickB;
      accept = clr_start && !modelBusy();
      if (accept) mSweepNext = 0;
      if (mInFrame && mPhase < 2) begin
        mPhase++;
      end else if (mSweepNext >= 0) begin
        mInFrame = 1;
        mPhase   = 0;
        mAddr    = 4'(mSweepNext);
        mData    = '0;
        mWho     = 2;
        mSweepNext = (mSweepNext == 15) ? -1 : mSweepNext + 1;
      end else if (req_a || req_b) begin
        pickB    = req_b && (!req_a || mFavourB);
        mFavourB = !pickB;
        mInFrame = 1;
        mPhase   = 0;
        mWho     = pickB ? 1 : 0;
        mAddr    = pickB ? addr_b : addr_a;
        mData    = pickB ? data_b : data_a;
      end else begin
        mInFrame = 0;
      end
    end
  end

  always @(negedge clk) begin
    bit expStrobe;
    expStrobe = mInFrame && (mPhase == 1);
    checkOutput("address", 32'(address), 32'(mAddr));
    checkOutput("wdata", 32'(wdata), 32'(mData));
    checkOutput("wclk", 32'(wclk), 32'(expStrobe));
    checkOutput("gnt_a", 32'(gnt_a), 32'(expStrobe && mWho == 0));
    checkOutput("gnt_b", 32'(gnt_b), 32'(expStrobe && mWho == 1));
    checkOutput("clr_busy", 32'(clr_busy), 32'(modelBusy()));
    if (wclk === 1'b1) begin
      wlog.push_back('{who: (gnt_a ? 0 : (gnt_b ? 1 : 2)), addr: address,
                       data: wdata, cyc: cyc});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic ra, input logic [3:0] aa, input logic [15:0] da,
                               input logic rb, input logic [3:0] ab, input logic [15:0] db,
                               input logic clr);
    req_a = ra; addr_a = aa; data_a = da;
    req_b = rb; addr_b = ab; data_b = db;
    clr_start = clr;
  endtask

  task automatic applyReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    wlog.delete();
  endtask

  initial begin
    // Reset state
    tick(2);
    checkOutput("rst address", 32'(address), 0);
    checkOutput("rst wclk", 32'(wclk), 0);
    checkOutput("rst busy", 32'(clr_busy), 0);
    checkOutput("rst gnt_a", 32'(gnt_a), 0);
    reset = 1'b0;
    tick(2);

    // Single A write; data_a changes after capture
    applyStimulus(1, 4'd5, 16'hBEEF, 0, 0, 0, 0);
    tick(1);
    checkOutput("A setup address", 32'(address), 5);
    checkOutput("A setup wdata", 32'(wdata), 32'hBEEF);
    checkOutput("A setup wclk", 32'(wclk), 0);
    data_a = 16'h1234;
    tick(1);
    checkOutput("A strobe wclk", 32'(wclk), 1);
    checkOutput("A strobe gnt_a", 32'(gnt_a), 1);
    checkOutput("A strobe wdata", 32'(wdata), 32'hBEEF);
    tick(1);
    req_a = 1'b0;
    checkOutput("A hold address", 32'(address), 5);
    checkOutput("A hold wclk", 32'(wclk), 0);
    tick(4);
    checkOutput("A log size", 32'(wlog.size()), 1);
    for (int i = 0; i < wlog.size(); i++)
      checkOutput("A log data", 32'(wlog[i].data), 32'hBEEF);

    // A and B held high: A,B,A,B every 3 cycles
    applyReset();
    applyStimulus(1, 4'd3, 16'h1111, 1, 4'd9, 16'h2222, 0);
    tick(12);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick(4);
    checkOutput("rr log size", 32'(wlog.size()), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      checkOutput("rr who", 32'(wlog[i].who), 32'(i % 2));
      checkOutput("rr addr", 32'(wlog[i].addr), (i % 2 == 0) ? 3 : 9);
      if (i > 0) checkOutput("rr spacing", 32'(wlog[i].cyc - wlog[i-1].cyc), 3);
    end

    // Clear sweep from IDLE, B requested mid-sweep
    applyReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    tick(1);
    clr_start = 1'b0;
    checkOutput("sweep busy k+1", 32'(clr_busy), 1);
    tick(10);
    applyStimulus(0, 0, 0, 1, 4'd7, 16'h7777, 0);
    tick(37);
    checkOutput("sweep busy k+48", 32'(clr_busy), 1);
    tick(1);
    checkOutput("sweep busy k+49", 32'(clr_busy), 0);
    checkOutput("B after sweep address", 32'(address), 7);
    tick(1);
    checkOutput("B after sweep gnt_b", 32'(gnt_b), 1);
    tick(1);
    req_b = 1'b0;
    tick(3);
    checkOutput("sweep log size", 32'(wlog.size()), 17);
    for (int i = 0; i < 16 && i < wlog.size(); i++) begin
      checkOutput("sweep addr", 32'(wlog[i].addr), 32'(i));
      checkOutput("sweep data", 32'(wlog[i].data), 0);
      checkOutput("sweep who", 32'(wlog[i].who), 2);
    end
    if (wlog.size() >= 17) begin
      checkOutput("sweep span", 32'(wlog[15].cyc - wlog[0].cyc), 45);
      checkOutput("B post-sweep data", 32'(wlog[16].data), 32'h7777);
    end

    // clr_start during A's SETUP; second clr_start mid-sweep ignored
    applyReset();
    applyStimulus(1, 4'd2, 16'hABCD, 0, 0, 0, 0);
    tick(1);
    clr_start = 1'b1;
    tick(1);
    clr_start = 1'b0;
    checkOutput("mid-frame busy", 32'(clr_busy), 1);
    checkOutput("mid-frame gnt_a", 32'(gnt_a), 1);
    tick(1);
    req_a = 1'b0;
    tick(20);
    clr_start = 1'b1;
    tick(1);
    clr_start = 1'b0;
    tick(40);
    checkOutput("late busy", 32'(clr_busy), 0);
    checkOutput("late log size", 32'(wlog.size()), 17);
    if (wlog.size() >= 17) begin
      checkOutput("late first who", 32'(wlog[0].who), 0);
      checkOutput("late first data", 32'(wlog[0].data), 32'hABCD);
      checkOutput("late sweep start", 32'(wlog[1].addr), 0);
      checkOutput("late sweep end", 32'(wlog[16].addr), 15);
    end

    // Reset in a STROBE cycle with a sweep pending
    applyReset();
    applyStimulus(1, 4'd4, 16'h5555, 0, 0, 0, 0);
    tick(1);
    clr_start = 1'b1;
    tick(1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("pre-reset wclk", 32'(wclk), 1);
    #1 reset = 1'b1;
    #1;
    checkOutput("async wclk", 32'(wclk), 0);
    checkOutput("async gnt_a", 32'(gnt_a), 0);
    checkOutput("async busy", 32'(clr_busy), 0);
    checkOutput("async address", 32'(address), 0);
    tick(1);
    reset = 1'b0;
    wlog.delete();
    tick(10);
    checkOutput("no resume log", 32'(wlog.size()), 0);
    checkOutput("no resume busy", 32'(clr_busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
